// File: rtl/mcpu_core_exn_seq_pkg.sv
// Exception cause codes and sequencer state encoding shared by the MCPU exception path.
package mcpu_core_exn_seq_pkg;

    localparam int EXN_CODE_W = 5;
    typedef logic [EXN_CODE_W-1:0] exn_code_t;

    localparam exn_code_t EXN_CODE_NOERR    = 5'h00;
    localparam exn_code_t EXN_CODE_INT      = 5'h01;
    localparam exn_code_t EXN_CODE_INST_PF  = 5'h02;
    localparam exn_code_t EXN_CODE_ILLEGAL  = 5'h03;
    localparam exn_code_t EXN_CODE_PRIV     = 5'h04;
    localparam exn_code_t EXN_CODE_SYSCALL  = 5'h05;
    localparam exn_code_t EXN_CODE_BREAK    = 5'h06;
    localparam exn_code_t EXN_CODE_DATA_PF  = 5'h07;
    localparam exn_code_t EXN_CODE_ALIGN    = 5'h08;
    localparam exn_code_t EXN_CODE_OVERFLOW = 5'h09;

    typedef enum logic [2:0] {
        EXN_SEQ_IDLE   = 3'd0,
        EXN_SEQ_DRAIN  = 3'd1,
        EXN_SEQ_FLUSH  = 3'd2,
        EXN_SEQ_VECTOR = 3'd3,
        EXN_SEQ_HALT   = 3'd4
    } exn_seq_state_e;

endpackage

// File: rtl/mcpu_core_exn_capture.sv
// EPC / EC0-3 / saved-IE register bank; loads on load_i, codes reset to EXN_CODE_NOERR.
module mcpu_core_exn_capture
    import mcpu_core_exn_seq_pkg::*;
#(
    parameter int PC_W = 28
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] pc_i,
    input  exn_code_t       ec0_i,
    input  exn_code_t       ec1_i,
    input  exn_code_t       ec2_i,
    input  exn_code_t       ec3_i,
    input  logic            ie_i,
    output logic [PC_W-1:0] epc_o,
    output exn_code_t       ec0_o,
    output exn_code_t       ec1_o,
    output exn_code_t       ec2_o,
    output exn_code_t       ec3_o,
    output logic            ie_save_o
);

    logic [PC_W-1:0] epc_q;
    exn_code_t       ec0_q, ec1_q, ec2_q, ec3_q;
    logic            ie_save_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            epc_q     <= '0;
            ec0_q     <= EXN_CODE_NOERR;
            ec1_q     <= EXN_CODE_NOERR;
            ec2_q     <= EXN_CODE_NOERR;
            ec3_q     <= EXN_CODE_NOERR;
            ie_save_q <= 1'b0;
        end else if (load_i) begin
            epc_q     <= pc_i;
            ec0_q     <= ec0_i;
            ec1_q     <= ec1_i;
            ec2_q     <= ec2_i;
            ec3_q     <= ec3_i;
            ie_save_q <= ie_i;
        end
    end

    assign epc_o     = epc_q;
    assign ec0_o     = ec0_q;
    assign ec1_o     = ec1_q;
    assign ec2_o     = ec2_q;
    assign ec3_o     = ec3_q;
    assign ie_save_o = ie_save_q;

endmodule

// File: rtl/mcpu_core_exn_seq.sv
// Exception entry (stall, drain, flush, capture, vector) and ERET return; all outputs registered.
// MCPU_EXN_DOUBLE_FAULT_EN: exception while in handler halts with double_fault until reset.
module mcpu_core_exn_seq
    import mcpu_core_exn_seq_pkg::*;
#(
    parameter int PC_W         = 28,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clkrst_core_clk,
    input  logic            clkrst_core_rst,
    input  logic            exception,
    input  logic [4:0]      combined_ec0,
    input  logic [4:0]      combined_ec1,
    input  logic [4:0]      combined_ec2,
    input  logic [4:0]      combined_ec3,
    input  logic [PC_W-1:0] pc_pc,
    input  logic            mem_busy,
    input  logic            eret,
    input  logic [PC_W-1:0] cr_eha,
    output logic            exn_stall,
    output logic            exn_flush,
    output logic            exn_redirect,
    output logic [PC_W-1:0] exn_redirect_pc,
    output logic            exn_cr_we,
    output logic [PC_W-1:0] exn_epc,
    output logic [4:0]      exn_ec0,
    output logic [4:0]      exn_ec1,
    output logic [4:0]      exn_ec2,
    output logic [4:0]      exn_ec3,
    output logic            interrupts_enabled,
    output logic            double_fault
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    exn_seq_state_e  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            stall_q, flush_q, redirect_q, cr_we_q, ie_q;
    logic [PC_W-1:0] redirect_pc_q;
    logic            ie_save;
    logic            cap_load;

`ifdef MCPU_EXN_DOUBLE_FAULT_EN
    logic in_handler_q, double_fault_q;
    // A nested fault must not overwrite the state the first handler is still using.
    assign cap_load     = (state_q == EXN_SEQ_IDLE) && exception && !in_handler_q;
    assign double_fault = double_fault_q;
`else
    assign cap_load     = (state_q == EXN_SEQ_IDLE) && exception;
    assign double_fault = 1'b0;
`endif

    mcpu_core_exn_capture #(.PC_W(PC_W)) u_capture (
        .clk_i     (clkrst_core_clk),
        .rst_i     (clkrst_core_rst),
        .load_i    (cap_load),
        .pc_i      (pc_pc),
        .ec0_i     (combined_ec0),
        .ec1_i     (combined_ec1),
        .ec2_i     (combined_ec2),
        .ec3_i     (combined_ec3),
        .ie_i      (ie_q),
        .epc_o     (exn_epc),
        .ec0_o     (exn_ec0),
        .ec1_o     (exn_ec1),
        .ec2_o     (exn_ec2),
        .ec3_o     (exn_ec3),
        .ie_save_o (ie_save)
    );

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q       <= EXN_SEQ_IDLE;
            cnt_q         <= '0;
            stall_q       <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            cr_we_q       <= 1'b0;
            ie_q          <= 1'b0;
`ifdef MCPU_EXN_DOUBLE_FAULT_EN
            in_handler_q   <= 1'b0;
            double_fault_q <= 1'b0;
`endif
        end else begin
            redirect_q <= 1'b0;
            cr_we_q    <= 1'b0;
            case (state_q)
                EXN_SEQ_IDLE: begin
                    // Exception has priority; a coincident ERET is dropped.
                    if (exception) begin
                        stall_q <= 1'b1;
`ifdef MCPU_EXN_DOUBLE_FAULT_EN
                        if (in_handler_q) begin
                            double_fault_q <= 1'b1;
                            state_q        <= EXN_SEQ_HALT;
                        end else begin
                            state_q <= EXN_SEQ_DRAIN;
                        end
`else
                        state_q <= EXN_SEQ_DRAIN;
`endif
                    end else if (eret) begin
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= exn_epc;
                        ie_q          <= ie_save;
`ifdef MCPU_EXN_DOUBLE_FAULT_EN
                        in_handler_q  <= 1'b0;
`endif
                    end
                end
                EXN_SEQ_DRAIN: begin
                    if (!mem_busy) begin
                        cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                        flush_q <= 1'b1;
                        state_q <= EXN_SEQ_FLUSH;
                    end
                end
                EXN_SEQ_FLUSH: begin
                    if (cnt_q == '0) begin
                        stall_q       <= 1'b0;
                        flush_q       <= 1'b0;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= cr_eha;
                        cr_we_q       <= 1'b1;
                        state_q       <= EXN_SEQ_VECTOR;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                EXN_SEQ_VECTOR: begin
                    ie_q    <= 1'b0;
                    state_q <= EXN_SEQ_IDLE;
`ifdef MCPU_EXN_DOUBLE_FAULT_EN
                    in_handler_q <= 1'b1;
`endif
                end
`ifdef MCPU_EXN_DOUBLE_FAULT_EN
                EXN_SEQ_HALT: state_q <= EXN_SEQ_HALT;
`endif
                default: state_q <= EXN_SEQ_IDLE;
            endcase
        end
    end

    assign exn_stall          = stall_q;
    assign exn_flush          = flush_q;
    assign exn_redirect       = redirect_q;
    assign exn_redirect_pc    = redirect_pc_q;
    assign exn_cr_we          = cr_we_q;
    assign interrupts_enabled = ie_q;

endmodule

// File: tb/tb_mcpu_core_exn_seq.sv
// Bench for mcpu_core_exn_seq: directed table, hand-written corner sequences, random run vs timeline model.
module tb_mcpu_core_exn_seq;
    import mcpu_core_exn_seq_pkg::*;

    localparam int PC_W = 28;
    localparam int FC   = 2;
`ifdef MCPU_EXN_DOUBLE_FAULT_EN
    localparam bit DF_EN = 1'b1;
`else
    localparam bit DF_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            exception = 1'b0, mem_busy = 1'b0, eret = 1'b0;
    logic [4:0]      combined_ec0 = '0, combined_ec1 = '0, combined_ec2 = '0, combined_ec3 = '0;
    logic [PC_W-1:0] pc_pc = '0, cr_eha = '0;
    logic            exn_stall, exn_flush, exn_redirect, exn_cr_we, interrupts_enabled, double_fault;
    logic [PC_W-1:0] exn_redirect_pc, exn_epc;
    logic [4:0]      exn_ec0, exn_ec1, exn_ec2, exn_ec3;

    mcpu_core_exn_seq #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
        .clkrst_core_clk    (clk),
        .clkrst_core_rst    (rst),
        .exception          (exception),
        .combined_ec0       (combined_ec0),
        .combined_ec1       (combined_ec1),
        .combined_ec2       (combined_ec2),
        .combined_ec3       (combined_ec3),
        .pc_pc              (pc_pc),
        .mem_busy           (mem_busy),
        .eret               (eret),
        .cr_eha             (cr_eha),
        .exn_stall          (exn_stall),
        .exn_flush          (exn_flush),
        .exn_redirect       (exn_redirect),
        .exn_redirect_pc    (exn_redirect_pc),
        .exn_cr_we          (exn_cr_we),
        .exn_epc            (exn_epc),
        .exn_ec0            (exn_ec0),
        .exn_ec1            (exn_ec1),
        .exn_ec2            (exn_ec2),
        .exn_ec3            (exn_ec3),
        .interrupts_enabled (interrupts_enabled),
        .double_fault       (double_fault)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an exception opens a timeline; once drain ends at edge t,
    // flush covers cycles t..t+FC-1 and the vector cycle is t+FC.
    int              cyc;
    bit              m_active, m_drain, m_halt, m_eret_redir, m_ie, m_ie_save, m_inh;
    int              m_flush_from, m_vec_at;
    logic [PC_W-1:0] m_epc, m_redir_pc;
    logic [3:0][4:0] m_ec;

    task automatic model_reset();
        m_active = 0; m_drain = 0; m_halt = 0; m_eret_redir = 0;
        m_ie = 0; m_ie_save = 0; m_inh = 0;
        m_flush_from = -1; m_vec_at = -1;
        m_epc = '0; m_redir_pc = '0;
        for (int i = 0; i < 4; i++) m_ec[i] = EXN_CODE_NOERR;
    endtask

    task automatic model_step();
        cyc++;
        m_eret_redir = 0;
        if (m_halt) begin
            m_halt = 1;
        end else if (!m_active) begin
            if (exception) begin
                if (DF_EN && m_inh) begin
                    m_halt = 1;
                end else begin
                    m_active = 1; m_drain = 1; m_flush_from = -1; m_vec_at = -1;
                    m_epc = pc_pc;
                    m_ec  = {combined_ec3, combined_ec2, combined_ec1, combined_ec0};
                    m_ie_save = m_ie;
                end
            end else if (eret) begin
                m_eret_redir = 1; m_redir_pc = m_epc; m_ie = m_ie_save; m_inh = 0;
            end
        end else if (m_vec_at >= 0 && cyc == m_vec_at + 1) begin
            m_active = 0; m_ie = 0; m_inh = 1;
        end else if (m_vec_at >= 0 && cyc == m_vec_at) begin
            m_redir_pc = cr_eha;
        end else if (m_drain && !mem_busy) begin
            m_drain = 0; m_flush_from = cyc; m_vec_at = cyc + FC;
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    bit mon_en = 0;
    initial forever begin
        @(negedge clk);
        if (mon_en && !rst) begin
            bit exp_stall, exp_flush, exp_we;
            exp_stall = m_halt || (m_active && (m_vec_at < 0 || cyc < m_vec_at));
            exp_flush = m_active && m_flush_from >= 0 && cyc >= m_flush_from && cyc < m_vec_at;
            exp_we    = m_active && m_vec_at >= 0 && cyc == m_vec_at;
            chk("mon_stall", exn_stall, exp_stall);
            chk("mon_flush", exn_flush, exp_flush);
            chk("mon_cr_we", exn_cr_we, exp_we);
            chk("mon_redirect", exn_redirect, exp_we || m_eret_redir);
            chk("mon_redirect_pc", exn_redirect_pc, m_redir_pc);
            chk("mon_epc", exn_epc, m_epc);
            chk("mon_ec0", exn_ec0, m_ec[0]);
            chk("mon_ec1", exn_ec1, m_ec[1]);
            chk("mon_ec2", exn_ec2, m_ec[2]);
            chk("mon_ec3", exn_ec3, m_ec[3]);
            chk("mon_ie", interrupts_enabled, m_ie);
            chk("mon_double_fault", double_fault, m_halt);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_stall"}, exn_stall, 0);
        chk({tag, "_flush"}, exn_flush, 0);
        chk({tag, "_redirect"}, exn_redirect, 0);
        chk({tag, "_redirect_pc"}, exn_redirect_pc, 0);
        chk({tag, "_cr_we"}, exn_cr_we, 0);
        chk({tag, "_epc"}, exn_epc, 0);
        chk({tag, "_ec0"}, exn_ec0, EXN_CODE_NOERR);
        chk({tag, "_ec1"}, exn_ec1, EXN_CODE_NOERR);
        chk({tag, "_ec2"}, exn_ec2, EXN_CODE_NOERR);
        chk({tag, "_ec3"}, exn_ec3, EXN_CODE_NOERR);
        chk({tag, "_ie"}, interrupts_enabled, 0);
        chk({tag, "_double_fault"}, double_fault, 0);
    endtask

    typedef struct {
        logic [3:0][4:0] ec;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] eha;
        int              d;
        bit              eret_too;
        int              exp_flush_k;
        int              exp_redir_k;
        logic [PC_W-1:0] exp_epc;
        logic [3:0][4:0] exp_ec;
    } vec_t;

    vec_t tbl [4];

    task automatic run_vec(input vec_t v, input string tag);
        int              flush_k = -1;
        int              redir_k = -1;
        logic [PC_W-1:0] rpc = '0;
        @(negedge clk);
        exception = 1; eret = v.eret_too; mem_busy = 0; pc_pc = v.pc; cr_eha = v.eha;
        {combined_ec3, combined_ec2, combined_ec1, combined_ec0} = v.ec;
        for (int k = 1; k <= 60 && redir_k < 0; k++) begin
            @(negedge clk);
            exception = 0; eret = 0; mem_busy = (k <= v.d);
            pc_pc = ~v.pc;
            {combined_ec3, combined_ec2, combined_ec1, combined_ec0} = ~v.ec;
            if (exn_flush && flush_k < 0) flush_k = k;
            if (exn_redirect) begin
                redir_k = k;
                rpc     = exn_redirect_pc;
            end
        end
        chk({tag, "_flush_cycle"}, flush_k, v.exp_flush_k);
        chk({tag, "_redirect_cycle"}, redir_k, v.exp_redir_k);
        chk({tag, "_redirect_pc"}, rpc, v.eha);
        chk({tag, "_epc"}, exn_epc, v.exp_epc);
        chk({tag, "_ec0"}, exn_ec0, v.exp_ec[0]);
        chk({tag, "_ec1"}, exn_ec1, v.exp_ec[1]);
        chk({tag, "_ec2"}, exn_ec2, v.exp_ec[2]);
        chk({tag, "_ec3"}, exn_ec3, v.exp_ec[3]);
    endtask

    initial begin
        int we_seen, redir_seen;
        tbl[0] = '{ec: {EXN_CODE_NOERR, EXN_CODE_NOERR, EXN_CODE_DATA_PF, EXN_CODE_NOERR},
                   pc: 28'h0000123, eha: 28'h0000400, d: 0, eret_too: 0,
                   exp_flush_k: 2, exp_redir_k: 4, exp_epc: 28'h0000123,
                   exp_ec: {EXN_CODE_NOERR, EXN_CODE_NOERR, EXN_CODE_DATA_PF, EXN_CODE_NOERR}};
        tbl[1] = '{ec: {EXN_CODE_NOERR, EXN_CODE_NOERR, EXN_CODE_NOERR, EXN_CODE_ILLEGAL},
                   pc: 28'h0ABCDEF, eha: 28'h0000400, d: 3, eret_too: 0,
                   exp_flush_k: 5, exp_redir_k: 7, exp_epc: 28'h0ABCDEF,
                   exp_ec: {EXN_CODE_NOERR, EXN_CODE_NOERR, EXN_CODE_NOERR, EXN_CODE_ILLEGAL}};
        tbl[2] = '{ec: {EXN_CODE_SYSCALL, EXN_CODE_NOERR, EXN_CODE_NOERR, EXN_CODE_NOERR},
                   pc: 28'hFFFFFFF, eha: 28'h0000800, d: 0, eret_too: 1,
                   exp_flush_k: 2, exp_redir_k: 4, exp_epc: 28'hFFFFFFF,
                   exp_ec: {EXN_CODE_SYSCALL, EXN_CODE_NOERR, EXN_CODE_NOERR, EXN_CODE_NOERR}};
        tbl[3] = '{ec: {EXN_CODE_PRIV, EXN_CODE_BREAK, EXN_CODE_INST_PF, EXN_CODE_OVERFLOW},
                   pc: 28'h0000000, eha: 28'hFFFFFF0, d: 1, eret_too: 0,
                   exp_flush_k: 3, exp_redir_k: 5, exp_epc: 28'h0000000,
                   exp_ec: {EXN_CODE_PRIV, EXN_CODE_BREAK, EXN_CODE_INST_PF, EXN_CODE_OVERFLOW}};

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 0;
        mon_en = 1;
        repeat (2) @(negedge clk);

        // Directed table, each vector followed by an ERET back to its EPC.
        for (int i = 0; i < 4; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_ie_after_vector", i), interrupts_enabled, 0);
            eret = 1;
            @(negedge clk);
            eret = 0;
            chk($sformatf("vec%0d_eret_redirect", i), exn_redirect, 1);
            chk($sformatf("vec%0d_eret_pc", i), exn_redirect_pc, tbl[i].exp_epc);
            chk($sformatf("vec%0d_eret_ie", i), interrupts_enabled, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_eret_strobe_once", i), exn_redirect, 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            exception    = ($urandom_range(0, 5) == 0);
            eret         = ($urandom_range(0, 4) == 0);
            mem_busy     = ($urandom_range(0, 2) == 0);
            pc_pc        = PC_W'($urandom);
            cr_eha       = PC_W'($urandom);
            combined_ec0 = 5'($urandom_range(0, 9));
            combined_ec1 = 5'($urandom_range(0, 9));
            combined_ec2 = 5'($urandom_range(0, 9));
            combined_ec3 = 5'($urandom_range(0, 9));
        end
        @(negedge clk);
        exception = 0; eret = 0; mem_busy = 0;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);

        // Asynchronous reset while flushing.
        exception = 1; pc_pc = 28'h0000555; cr_eha = 28'h0000400;
        combined_ec2 = EXN_CODE_ALIGN;
        @(negedge clk);
        exception = 0;
        @(negedge clk);
        chk("pre_rst_flush", exn_flush, 1);
        #2 rst = 1;
        #1 check_reset_vals("arst");
        repeat (2) @(negedge clk);
        rst = 0;
        we_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (exn_cr_we) we_seen++;
        end
        chk("no_cr_we_after_rst", we_seen, 0);

        // Second exception before ERET.
        run_vec(tbl[0], "first");
        repeat (2) @(negedge clk);
        exception = 1; pc_pc = 28'h0000777;
        {combined_ec3, combined_ec2, combined_ec1, combined_ec0} =
            {EXN_CODE_NOERR, EXN_CODE_NOERR, EXN_CODE_ALIGN, EXN_CODE_NOERR};
        @(negedge clk);
        exception = 0;
`ifdef MCPU_EXN_DOUBLE_FAULT_EN
        we_seen = 0; redir_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (exn_cr_we) we_seen++;
            if (exn_redirect) redir_seen++;
        end
        chk("df_double_fault", double_fault, 1);
        chk("df_stall_held", exn_stall, 1);
        chk("df_no_redirect", redir_seen, 0);
        chk("df_no_cr_we", we_seen, 0);
        chk("df_epc_kept", exn_epc, 28'h0000123);
`else
        redir_seen = 0; we_seen = 0;
        for (int k = 0; k < 40 && redir_seen == 0; k++) begin
            @(negedge clk);
            if (exn_redirect) redir_seen = 1;
        end
        chk("nested_redirect_seen", redir_seen, 1);
        chk("nested_epc", exn_epc, 28'h0000777);
        chk("nested_ec1", exn_ec1, EXN_CODE_ALIGN);
        chk("nested_double_fault", double_fault, 0);
`endif
        repeat (3) @(negedge clk);
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mcpu_core_exn_seq.md
# mcpu_core_exn_seq

Exception sequencer for the MCPU core. It takes the per-lane exception codes and the qualified `exception` flag from the PC-stage exception encoder, and runs the exception entry sequence: stall the front end, drain outstanding memory operations, flush the pipeline, capture EPC and EC0–EC3, and redirect fetch to the handler. It also owns the `interrupts_enabled` state that feeds back into the encoder, and handles ERET return.

## Interface
- `PC_W`, 28: packet-address width (16-byte packets).
- `FLUSH_CYCLES`, 2: cycles `exn_flush` is held; must be ≥1.
- `clkrst_core_clk`  in  1  core clock.
- `clkrst_core_rst`  in  1  reset, asynchronous, active-high.
- `exception`  in  1  encoder exception flag, already qualified by `pc_valid`.
- `combined_ec0..3`  in  5 each  per-lane exception codes.
- `pc_pc`  in  PC_W  packet address of the PC-stage packet.
- `mem_busy`  in  1  memory operations are outstanding.
- `eret`  in  1  an ERET commits in the PC stage.
- `cr_eha`  in  PC_W  exception handler address, from the control register.
- `exn_stall`  out  1  freeze fetch and decode.
- `exn_flush`  out  1  kill every in-flight packet younger than the PC stage.
- `exn_redirect`  out  1  one-cycle fetch redirect strobe.
- `exn_redirect_pc`  out  PC_W  redirect target.
- `exn_cr_we`  out  1  one-cycle strobe to write EPC, EC0–3 and saved IE into the control registers.
- `exn_epc`  out  PC_W  captured EPC.
- `exn_ec0..3`  out  5 each  captured exception codes.
- `interrupts_enabled`  out  1  global interrupt enable; feeds the encoder.
- `double_fault`  out  1  sticky halt indication; present only with the macro, otherwise tied 0.

## Operation
- States: IDLE, DRAIN, FLUSH, VECTOR, plus HALT when the macro is defined.
- **IDLE**
  - When `exception`=1, latch `pc_pc` and `combined_ec0..3`, latch `ie_save` from `interrupts_enabled`, set `exn_stall`, and go to DRAIN.
  - When `eret`=1 and `exception`=0, assert `exn_redirect` with `exn_redirect_pc` = `exn_epc`, restore `interrupts_enabled` from `ie_save`, and clear `in_handler`. The state stays IDLE.
  - When `exception` and `eret` are both 1, the exception wins and the ERET is dropped.
- **DRAIN**
  - Hold `exn_stall`.
  - When `mem_busy`=0, load the flush counter with `FLUSH_CYCLES-1` and go to FLUSH. Otherwise stay in DRAIN; there is no timeout.
- **FLUSH**
  - Assert `exn_stall` and `exn_flush`.
  - Decrement the counter and go to VECTOR when it reaches 0.
- **VECTOR**
  - Single cycle with `exn_cr_we`=1, `exn_redirect`=1 and `exn_redirect_pc` = `cr_eha`.
  - Clear `interrupts_enabled`, set `in_handler`, return to IDLE.
- `exception` or `eret` arriving outside IDLE is ignored, since the pipeline is stalled or flushed at that point.
- EPC is always the packet address of the faulting packet, for every cause. Handler software advances it past SYSCALL or BREAK.
- `exn_epc` and `exn_ec*` hold their values until the next capture.

## Timing
- Reset values:
  - State IDLE.
  - All strobes, `exn_stall`, `exn_flush` and `double_fault` are 0.
  - `exn_epc`=0, `exn_redirect_pc`=0, `exn_ec0..3`=`EXN_CODE_NOERR`.
  - `interrupts_enabled`=0, `ie_save`=0, `in_handler`=0.
- Reset mid-sequence aborts to IDLE immediately; no partial control-register write occurs.
- Exception sampled at cycle N (registered transition):
  - DRAIN at N+1; `exn_stall` is visible from N+1.
  - FLUSH from N+2+D, where D is the number of cycles with `mem_busy`=1 in DRAIN.
  - VECTOR at N+2+D+`FLUSH_CYCLES`; default redirect is N+4 when D=0.
- ERET redirect is registered: `eret` at cycle N gives `exn_redirect` at N+1.
- All outputs are registered.

## Configuration
- `MCPU_EXN_DOUBLE_FAULT_EN`, defined:
  - An exception sampled in IDLE while `in_handler`=1 sets `double_fault`=1 and enters HALT.
  - HALT holds `exn_stall`=1 and never redirects; it is left only by reset.
  - No control-register write occurs on that exception.
- Undefined:
  - A nested exception runs the normal sequence and overwrites EPC/EC.
  - There is no HALT state, and `double_fault` is tied 0.

## Structure
- Shared package/include `exn_codes.vh` holds:
  - all `EXN_CODE_*` constants, including `EXN_CODE_NOERR`;
  - the state encoding `EXN_SEQ_IDLE/DRAIN/FLUSH/VECTOR/HALT`.
- Sub-module `mcpu_core_exn_capture`: the EPC/EC0–3/IE capture register bank, with load enable and reset to `EXN_CODE_NOERR`.

## Test plan
- **Exception, no drain.** Lane-1 `EXN_CODE_DATA_PF`, `pc_pc`=0x0000123, `mem_busy`=0, `cr_eha`=0x0000400, `FLUSH_CYCLES`=2 -> redirect to 0x0000400 at N+4; `exn_epc`=0x0000123; `exn_ec1`=DATA_PF; others NOERR; `interrupts_enabled`=0.
- **Drain.** `mem_busy` held 1 for 3 cycles after the exception -> `exn_flush` first asserts at N+5; redirect at N+7.
- **Simultaneous exception and ERET.** `exception`=1 and `eret`=1 in the same cycle -> exception sequence runs; no ERET redirect occurs.
- **ERET return.** Interrupt taken with `interrupts_enabled`=1, then `eret` -> redirect to the saved EPC one cycle later; `interrupts_enabled` returns to 1; `in_handler`=0.
- **Reset mid-sequence.** Reset asserted during FLUSH -> all outputs return to reset values asynchronously; no `exn_cr_we` pulse.
- **Double fault (macro defined).** Second exception before ERET -> `double_fault`=1; `exn_stall` held; no redirect for 100 cycles.
